multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl_if.sv | 35 +++
 rtl/multicycle_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - instruction/flag inputs and datapath control outputs of the multicycle controller
interface multicycle_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       overflow;
  logic       mem_ready;
  logic [3:0] alu_control;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic       pc_en;
  logic       ir_write;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       exc;
  logic [1:0] exc_cause;
  logic [3:0] state;

  modport master (
    input  opcode, funct, zero, overflow, mem_ready,
    output alu_control, alu_src_a, alu_src_b, pc_src, pc_en, ir_write, i_or_d,
           mem_read, mem_write, reg_write, reg_dst, mem_to_reg, exc, exc_cause, state
  );

  modport slave (
    output opcode, funct, zero, overflow, mem_ready,
    input  alu_control, alu_src_a, alu_src_b, pc_src, pc_en, ir_write, i_or_d,
           mem_read, mem_write, reg_write, reg_dst, mem_to_reg, exc, exc_cause, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle MIPS-subset control FSM with illegal-instruction and overflow exceptions
module multicycle_ctrl #(
  parameter bit EXC_ON_OVF = 1'b1
) (
  input logic             clk,
  input logic             rst,
  multicycle_ctrl_if.master bus
);
  localparam logic [3:0] FETCH   = 4'd0;
  localparam logic [3:0] DECODE  = 4'd1;
  localparam logic [3:0] MEMADR  = 4'd2;
  localparam logic [3:0] MEMRD   = 4'd3;
  localparam logic [3:0] MEMWB   = 4'd4;
  localparam logic [3:0] MEMWR   = 4'd5;
  localparam logic [3:0] EXEC    = 4'd6;
  localparam logic [3:0] ALUWB   = 4'd7;
  localparam logic [3:0] BRANCH  = 4'd8;
  localparam logic [3:0] ADDIEX  = 4'd9;
  localparam logic [3:0] ADDIWB  = 4'd10;
  localparam logic [3:0] JUMP    = 4'd11;
  localparam logic [3:0] ILLEGAL = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  logic [3:0] state_q, state_d;
  logic       ovf_q, ovf_d;
  logic [3:0] cur;
  logic [3:0] r_alu;
  logic       r_valid;
  logic       r_addsub;
  logic       wb_ovf;

  logic [3:0] alu_control;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic       pc_en, ir_write, i_or_d, mem_read, mem_write;
  logic       reg_write, reg_dst, mem_to_reg, exc;
  logic [1:0] exc_cause;

  // Strobes decode from FETCH while reset is held so nothing stale leaks out.
  assign cur    = rst ? FETCH : state_q;
  assign wb_ovf = ovf_q && EXC_ON_OVF;

  always_comb begin
    r_alu    = ALU_ADD;
    r_valid  = 1'b1;
    r_addsub = 1'b0;
    case (bus.funct)
      6'b100000: r_addsub = 1'b1;
      6'b100010: begin r_alu = ALU_SUB; r_addsub = 1'b1; end
      6'b100100: r_alu = ALU_AND;
      6'b100101: r_alu = ALU_OR;
      6'b101010: r_alu = ALU_SLT;
      default:   r_valid = 1'b0;
    endcase
  end

  always_comb begin
    alu_control = ALU_ADD;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    pc_src      = 2'b00;
    pc_en       = 1'b0;
    ir_write    = 1'b0;
    i_or_d      = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    exc         = 1'b0;
    exc_cause   = 2'b00;
    state_d     = FETCH;
    ovf_d       = ovf_q;
    case (cur)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = bus.mem_ready;
        pc_en     = bus.mem_ready;
        state_d   = bus.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXEC;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default:      state_d = ILLEGAL;
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (bus.opcode == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        i_or_d   = 1'b1;
        mem_read = 1'b1;
        state_d  = bus.mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEMWR: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
        state_d   = bus.mem_ready ? FETCH : MEMWR;
      end
      EXEC: begin
        alu_src_a   = 1'b1;
        alu_control = r_alu;
        ovf_d       = bus.overflow & r_addsub;
        state_d     = r_valid ? ALUWB : ILLEGAL;
      end
      ALUWB, ADDIWB: begin
        reg_dst = (cur == ALUWB);
        if (wb_ovf) begin
          exc       = 1'b1;
          exc_cause = 2'b10;
        end else begin
          reg_write = 1'b1;
        end
      end
      BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_src      = 2'b01;
        pc_en       = bus.zero;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        ovf_d     = bus.overflow;
        state_d   = ADDIWB;
      end
      JUMP: begin
        pc_src = 2'b10;
        pc_en  = 1'b1;
      end
      ILLEGAL: begin
        exc       = 1'b1;
        exc_cause = 2'b01;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.alu_control = alu_control;
  assign bus.alu_src_a   = alu_src_a;
  assign bus.alu_src_b   = alu_src_b;
  assign bus.pc_src      = pc_src;
  assign bus.pc_en       = pc_en;
  assign bus.ir_write    = ir_write;
  assign bus.i_or_d      = i_or_d;
  assign bus.mem_read    = mem_read;
  assign bus.mem_write   = mem_write;
  assign bus.reg_write   = reg_write;
  assign bus.reg_dst     = reg_dst;
  assign bus.mem_to_reg  = mem_to_reg;
  assign bus.exc         = exc;
  assign bus.exc_cause   = exc_cause;
  assign bus.state       = state_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - vector table, corner sequences and randomized instruction-level model for multicycle_ctrl
module tb_multicycle_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       overflow = 1'b0;
  logic       mem_ready = 1'b0;

  always #5 clk = ~clk;

  multicycle_ctrl_if b0 ();
  multicycle_ctrl_if b1 ();

  assign b0.opcode = opcode;    assign b1.opcode = opcode;
  assign b0.funct = funct;      assign b1.funct = funct;
  assign b0.zero = zero;        assign b1.zero = zero;
  assign b0.overflow = overflow; assign b1.overflow = overflow;
  assign b0.mem_ready = mem_ready; assign b1.mem_ready = mem_ready;

  multicycle_ctrl #(.EXC_ON_OVF(1'b1)) u0 (.clk(clk), .rst(rst), .bus(b0.master));
  multicycle_ctrl #(.EXC_ON_OVF(1'b0)) u1 (.clk(clk), .rst(rst), .bus(b1.master));

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic       rst;
    logic [5:0] op;
    logic       z;
    logic       mr;
    logic       chk;
    logic [3:0] st;
    logic       mrd;
    logic       mwr;
    logic       iord;
    logic       rw;
    logic       pcen;
    logic [1:0] pcs;
    logic       exc;
    logic [1:0] cause;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [5:0] op, input logic z, input logic mr,
                     input logic chk, input logic [3:0] st, input logic mrd, input logic mwr,
                     input logic iord, input logic rw, input logic pcen, input logic [1:0] pcs,
                     input logic exc, input logic [1:0] cause);
    vec_t v;
    v = '{r, op, z, mr, chk, st, mrd, mwr, iord, rw, pcen, pcs, exc, cause};
    vecs.push_back(v);
  endtask

  task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic z,
                      input logic ov, input logic mr);
    @(negedge clk);
    opcode = op; funct = fn; zero = z; overflow = ov; mem_ready = mr;
    #1;
  endtask

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BQ = 6'b000100, AI = 6'b001000, JP = 6'b000010, XX = 6'b111111;

  logic [13:0] act_v, exp_v;
  logic [5:0]  fn_tab [5];

  initial begin
    fn_tab[0] = 6'b100000; fn_tab[1] = 6'b100010; fn_tab[2] = 6'b100100;
    fn_tab[3] = 6'b100101; fn_tab[4] = 6'b101010;

    //  rst op  z  mr chk st  mrd mwr iord rw pcen pcs exc cause
    add(1, LW, 0, 1, 0, 0,  1, 0, 0, 0, 1, 2'd0, 0, 2'd0);
    add(1, LW, 0, 1, 1, 0,  1, 0, 0, 0, 1, 2'd0, 0, 2'd0);
    add(0, LW, 0, 1, 1, 0,  1, 0, 0, 0, 1, 2'd0, 0, 2'd0);
    add(0, LW, 0, 1, 1, 1,  0, 0, 0, 0, 0, 2'd0, 0, 2'd0);
    add(0, LW, 0, 1, 1, 2,  0, 0, 0, 0, 0, 2'd0, 0, 2'd0);
    add(0, LW, 0, 1, 1, 3,  1, 0, 1, 0, 0, 2'd0, 0, 2'd0);
    add(0, LW, 0, 1, 1, 4,  0, 0, 0, 1, 0, 2'd0, 0, 2'd0);
    add(0, XX, 0, 1, 1, 0,  1, 0, 0, 0, 1, 2'd0, 0, 2'd0);
    add(0, XX, 0, 1, 1, 1,  0, 0, 0, 0, 0, 2'd0, 0, 2'd0);
    add(0, XX, 0, 1, 1, 12, 0, 0, 0, 0, 0, 2'd0, 1, 2'd1);
    add(0, BQ, 0, 1, 1, 0,  1, 0, 0, 0, 1, 2'd0, 0, 2'd0);
    add(0, BQ, 0, 1, 1, 1,  0, 0, 0, 0, 0, 2'd0, 0, 2'd0);
    add(0, BQ, 1, 1, 1, 8,  0, 0, 0, 0, 1, 2'd1, 0, 2'd0);
    add(0, BQ, 0, 1, 1, 0,  1, 0, 0, 0, 1, 2'd0, 0, 2'd0);
    add(0, BQ, 0, 1, 1, 1,  0, 0, 0, 0, 0, 2'd0, 0, 2'd0);
    add(0, BQ, 0, 1, 1, 8,  0, 0, 0, 0, 0, 2'd1, 0, 2'd0);
    add(0, SW, 0, 1, 1, 0,  1, 0, 0, 0, 1, 2'd0, 0, 2'd0);
    add(0, SW, 0, 1, 1, 1,  0, 0, 0, 0, 0, 2'd0, 0, 2'd0);
    add(0, SW, 0, 1, 1, 2,  0, 0, 0, 0, 0, 2'd0, 0, 2'd0);
    add(0, SW, 0, 0, 1, 5,  0, 1, 1, 0, 0, 2'd0, 0, 2'd0);
    add(0, SW, 0, 0, 1, 5,  0, 1, 1, 0, 0, 2'd0, 0, 2'd0);
    add(0, SW, 0, 0, 1, 5,  0, 1, 1, 0, 0, 2'd0, 0, 2'd0);
    add(0, SW, 0, 1, 1, 5,  0, 1, 1, 0, 0, 2'd0, 0, 2'd0);
    add(0, LW, 0, 1, 1, 0,  1, 0, 0, 0, 1, 2'd0, 0, 2'd0);
    add(0, LW, 0, 1, 1, 1,  0, 0, 0, 0, 0, 2'd0, 0, 2'd0);
    add(0, LW, 0, 1, 1, 2,  0, 0, 0, 0, 0, 2'd0, 0, 2'd0);
    add(0, LW, 0, 0, 1, 3,  1, 0, 1, 0, 0, 2'd0, 0, 2'd0);
    add(1, LW, 0, 0, 1, 3,  1, 0, 0, 0, 0, 2'd0, 0, 2'd0);
    add(0, LW, 0, 0, 1, 0,  1, 0, 0, 0, 0, 2'd0, 0, 2'd0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; opcode = vecs[i].op; funct = 6'd0;
      zero = vecs[i].z; overflow = 1'b0; mem_ready = vecs[i].mr;
      #1;
      act_v = {vecs[i].chk ? b0.state : vecs[i].st, b0.mem_read, b0.mem_write, b0.i_or_d,
               b0.reg_write, b0.pc_en, b0.pc_src, b0.exc, b0.exc_cause};
      exp_v = {vecs[i].st, vecs[i].mrd, vecs[i].mwr, vecs[i].iord, vecs[i].rw,
               vecs[i].pcen, vecs[i].pcs, vecs[i].exc, vecs[i].cause};
      check($sformatf("vec%0d", i), 32'(act_v), 32'(exp_v));
    end

    // R-type SUB overflowing: exception only when EXC_ON_OVF is set
    step(RT, 6'b100010, 0, 0, 1);
    check("rsub_fetch_st", 32'(b0.state), 32'd0);
    step(RT, 6'b100010, 0, 0, 1);
    step(RT, 6'b100010, 0, 1, 1);
    check("rsub_exec_st", 32'(b0.state), 32'd6);
    check("rsub_exec_alu", 32'(b0.alu_control), 32'b0110);
    step(RT, 6'b100010, 0, 0, 1);
    check("ovf1_wb", 32'({b0.state, b0.reg_dst, b0.reg_write, b0.exc, b0.exc_cause}),
          32'({4'd7, 1'b1, 1'b0, 1'b1, 2'b10}));
    check("ovf0_wb", 32'({b1.state, b1.reg_dst, b1.reg_write, b1.exc, b1.exc_cause}),
          32'({4'd7, 1'b1, 1'b1, 1'b0, 2'b00}));
    step(RT, 6'b000111, 0, 0, 1);
    check("ovf_ret_st", 32'({b0.state, b1.state}), 32'd0);
    step(RT, 6'b000111, 0, 0, 1);
    step(RT, 6'b000111, 0, 0, 1);
    check("badfn_exec_st", 32'(b0.state), 32'd6);
    step(RT, 6'b000111, 0, 0, 1);
    check("badfn_ill", 32'({b0.state, b0.exc, b0.exc_cause, b0.reg_write}),
          32'({4'd12, 1'b1, 2'b01, 1'b0}));
    step(LW, 6'd0, 0, 0, 0);
    check("badfn_ret", 32'({b0.state, b0.exc}), 32'd0);

    // Randomized instruction stream checked per instruction against counts from the ISA rules
    for (int n = 0; n < 300; n++) begin
      int kind, wf, wm, len, base, c0_rw, c1_rw, c0_exc, c1_exc, n_mwr, n_mrd, n_pcen, n_irw;
      logic [5:0] op, fn;
      logic [1:0] cause0;
      logic zk, ok, is_mem, is_lw, is_sw, fn_ok, fn_addsub;
      int e_rw0, e_rw1, e_exc0, e_mrd, e_mwr, e_pcen;
      logic [1:0] e_cause0;
      kind = $urandom_range(0, 6);
      fn = 6'd0; fn_ok = 1'b0; fn_addsub = 1'b0;
      case (kind)
        0: op = LW;
        1: op = SW;
        2: begin
          op = RT;
          if ($urandom_range(0, 5) == 0) begin
            fn = 6'b000111;
          end else begin
            fn = fn_tab[$urandom_range(0, 4)];
            fn_ok = 1'b1;
            fn_addsub = (fn == 6'b100000) || (fn == 6'b100010);
          end
        end
        3: op = AI;
        4: op = BQ;
        5: op = JP;
        default: op = 6'($urandom_range(48, 63));
      endcase
      is_lw = (kind == 0); is_sw = (kind == 1); is_mem = is_lw || is_sw;
      wf = $urandom_range(0, 3);
      wm = $urandom_range(0, 3);
      case (kind)
        0: base = 5;
        1, 2, 3: base = 4;
        default: base = 3;
      endcase
      len = base + wf + (is_mem ? wm : 0);
      c0_rw = 0; c1_rw = 0; c0_exc = 0; c1_exc = 0; n_mwr = 0; n_mrd = 0; n_pcen = 0; n_irw = 0;
      cause0 = 2'b00; zk = 1'b0; ok = 1'b0;
      for (int c = 0; c < len; c++) begin
        logic mr;
        if (c < wf) mr = 1'b0;
        else if (c == wf) mr = 1'b1;
        else if (is_mem && c >= wf + 3 && c < wf + 3 + wm) mr = 1'b0;
        else if (is_mem && c == wf + 3 + wm) mr = 1'b1;
        else mr = 1'($urandom_range(0, 1));
        step(op, fn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), mr);
        if (c == wf + 2) begin zk = zero; ok = overflow; end
        if (c == 0) check($sformatf("rnd%0d_start", n), 32'({b0.state, b1.state}), 32'd0);
        c0_rw += int'(b0.reg_write); c1_rw += int'(b1.reg_write);
        c0_exc += int'(b0.exc); c1_exc += int'(b1.exc);
        cause0 |= b0.exc_cause;
        n_mwr += int'(b0.mem_write); n_mrd += int'(b0.mem_read);
        n_pcen += int'(b0.pc_en); n_irw += int'(b0.ir_write);
      end
      e_rw0 = 0; e_rw1 = 0; e_exc0 = 0; e_cause0 = 2'b00;
      if (is_lw) begin e_rw0 = 1; e_rw1 = 1; end
      if ((kind == 2 && fn_ok) || kind == 3) begin
        e_rw1 = 1;
        if (ok && (kind == 3 || fn_addsub)) begin e_exc0 = 1; e_cause0 = 2'b10; end
        else e_rw0 = 1;
      end
      if ((kind == 2 && !fn_ok) || kind == 6) begin e_exc0 = 1; e_cause0 = 2'b01; end
      e_mrd = wf + 1 + (is_lw ? wm + 1 : 0);
      e_mwr = is_sw ? wm + 1 : 0;
      e_pcen = 1 + ((kind == 4 && zk) ? 1 : 0) + (kind == 5 ? 1 : 0);
      check($sformatf("rnd%0d_rw0", n), 32'(c0_rw), 32'(e_rw0));
      check($sformatf("rnd%0d_rw1", n), 32'(c1_rw), 32'(e_rw1));
      check($sformatf("rnd%0d_exc0", n), 32'({c0_exc, cause0}), 32'({e_exc0, e_cause0}));
      check($sformatf("rnd%0d_exc1", n), 32'(c1_exc), 32'((e_cause0 == 2'b01) ? 1 : 0));
      check($sformatf("rnd%0d_mem", n), 32'({n_mrd, n_mwr}), 32'({e_mrd, e_mwr}));
      check($sformatf("rnd%0d_pc", n), 32'({n_pcen, n_irw}), 32'({e_pcen, 1}));
    end
    step(LW, 6'd0, 0, 0, 0);
    check("rnd_end_st", 32'({b0.state, b1.state}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
